fpdiv_ctrl: RTL and testbench

Sequencing FSM for the Goldschmidt fpdiv datapath. It replaces hand-driven bench stimulus on sel_mux4, sel_mux3, en_a, en_b and en_rem.
- On a start pulse it runs one initial-approximation (IA) iteration, then ITERS-1 refinement iterations, then one remainder capture, then flags done.
- It sits beside fpdiv and drives its mux selects and register enables directly.

---
 rtl/fpdiv_ctrl_pkg.sv | 25 ++
 rtl/fpdiv_ctrl.sv | 150 +++++++++++++++
 tb/tb_fpdiv_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fpdiv_ctrl_pkg.sv
// Shared types and operand-select encodings for the Goldschmidt fpdiv datapath
// and its sequencing controller.
package fpdiv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IA_A = 3'd1,
    IA_B = 3'd2,
    IT_A = 3'd3,
    IT_B = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Multiplier operand select (mux4) and factor select (mux3) encodings.
  localparam logic [1:0] MUX4_NUM_IA = 2'b00;
  localparam logic [1:0] MUX4_DEN_IA = 2'b01;
  localparam logic [1:0] MUX4_A_C    = 2'b10;
  localparam logic [1:0] MUX4_B_C    = 2'b11;

  localparam logic [1:0] MUX3_IA     = 2'b00;
  localparam logic [1:0] MUX3_C      = 2'b01;
  localparam logic [1:0] MUX3_REM    = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for fpdiv: IA iteration, ITERS-1 refinements, remainder capture, done.
// Optional abort input is enabled by defining FPDIV_CTRL_ABORT_EN.
module fpdiv_ctrl
  import fpdiv_ctrl_pkg::*;
#(
  parameter int ITERS = 6,
  parameter int CNT_W = $clog2(ITERS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef FPDIV_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] sel_mux4,
  output logic [1:0] sel_mux3,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_t           state_r;
  state_t           state_next_s;
  state_t           seq_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] seq_cnt_s;

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Nominal sequencing; cnt_r counts completed iterations, IA counting as the first.
  always_comb begin
    seq_next_s = state_r;
    seq_cnt_s  = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          seq_next_s = IA_A;
        end else begin
          seq_next_s = IDLE;
        end
      end
      IA_A: begin
        seq_next_s = IA_B;
        seq_cnt_s  = CNT_W'(1);
      end
      IA_B: seq_next_s = IT_A;
      IT_A: seq_next_s = IT_B;
      IT_B: begin
        seq_cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r < LAST_CNT) begin
          seq_next_s = IT_A;
        end else begin
          seq_next_s = REM;
        end
      end
      REM:  seq_next_s = DONE;
      DONE: seq_next_s = IDLE;
      default: begin
        seq_next_s = IDLE;
        seq_cnt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

`ifdef FPDIV_CTRL_ABORT_EN
  logic active_s;
  assign active_s = (state_r != IDLE) && (state_r != DONE);

  // Abort overrides sequencing while an operation is in flight.
  always_comb begin
    if (abort && active_s) begin
      state_next_s = IDLE;
      cnt_next_s   = {CNT_W{1'b0}};
    end else begin
      state_next_s = seq_next_s;
      cnt_next_s   = seq_cnt_s;
    end
  end
`else
  assign state_next_s = seq_next_s;
  assign cnt_next_s   = seq_cnt_s;
`endif

  // Output decode from registered state only.
  always_comb begin
    sel_mux4 = MUX4_NUM_IA;
    sel_mux3 = MUX3_IA;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      IA_A: begin
        sel_mux4 = MUX4_NUM_IA;
        sel_mux3 = MUX3_IA;
        en_a     = 1'b1;
        busy     = 1'b1;
      end
      IA_B: begin
        sel_mux4 = MUX4_DEN_IA;
        sel_mux3 = MUX3_IA;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      IT_A: begin
        sel_mux4 = MUX4_A_C;
        sel_mux3 = MUX3_C;
        en_a     = 1'b1;
        busy     = 1'b1;
      end
      IT_B: begin
        sel_mux4 = MUX4_B_C;
        sel_mux3 = MUX3_C;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      REM: begin
        sel_mux4 = MUX4_A_C;
        sel_mux3 = MUX3_REM;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed, table-driven bench for fpdiv_ctrl (ITERS=6 main instance, ITERS=2 side instance).
`timescale 1ns/1ps
module tb_fpdiv_ctrl;

  // Expected output word: {sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done}
  localparam logic [8:0] E_IDLE = 9'b00_00_000_0_0;
  localparam logic [8:0] E_IAA  = 9'b00_00_100_1_0;
  localparam logic [8:0] E_IAB  = 9'b01_00_010_1_0;
  localparam logic [8:0] E_ITA  = 9'b10_01_100_1_0;
  localparam logic [8:0] E_ITB  = 9'b11_01_010_1_0;
  localparam logic [8:0] E_REM  = 9'b10_10_001_1_0;
  localparam logic [8:0] E_DONE = 9'b00_00_000_0_1;

  typedef struct {
    logic       start;
    logic       reset;
    logic       abort;
    logic [8:0] exp;
    int         tag;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] sel_mux4, sel_mux3;
  logic       en_a, en_b, en_rem, busy, done;

  logic       reset2 = 1'b1;
  logic       start2 = 1'b0;
  logic [1:0] sel_mux4_2, sel_mux3_2;
  logic       en_a_2, en_b_2, en_rem_2, busy_2, done_2;

`ifdef FPDIV_CTRL_ABORT_EN
  logic abort  = 1'b0;
  logic abort2 = 1'b0;
`endif

  fpdiv_ctrl #(.ITERS(6)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef FPDIV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .sel_mux4(sel_mux4), .sel_mux3(sel_mux3),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .busy(busy), .done(done)
  );

  fpdiv_ctrl #(.ITERS(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
`ifdef FPDIV_CTRL_ABORT_EN
    .abort(abort2),
`endif
    .sel_mux4(sel_mux4_2), .sel_mux3(sel_mux3_2),
    .en_a(en_a_2), .en_b(en_b_2), .en_rem(en_rem_2), .busy(busy_2), .done(done_2)
  );

  wire [8:0] obs  = {sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done};
  wire [8:0] obs2 = {sel_mux4_2, sel_mux3_2, en_a_2, en_b_2, en_rem_2, busy_2, done_2};

  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  // Reference outputs of cycle c of an undisturbed ITERS=6 operation (start at edge 0).
  function automatic logic [8:0] exp_of(input int c);
    if (c == 1)                 return E_IAA;
    else if (c == 2)            return E_IAB;
    else if (c >= 3 && c <= 12) return (c % 2 == 1) ? E_ITA : E_ITB;
    else if (c == 13)           return E_REM;
    else if (c == 14)           return E_DONE;
    else                        return E_IDLE;
  endfunction

  task automatic check(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic a, input logic [8:0] e, input int tag);
    vec_t v;
    v.start = s; v.reset = r; v.abort = a; v.exp = e; v.tag = tag;
    vq.push_back(v);
  endtask

  // One full operation: start at edge 0, start_mask[k] drives start at edge k (1..14).
  task automatic add_op(input logic [15:0] start_mask, input int tag);
    add(1'b1, 1'b0, 1'b0, E_IAA, tag);
    for (int k = 1; k <= 14; k++)
      add(start_mask[k], 1'b0, 1'b0, exp_of(k + 1), tag);
  endtask

  logic [8:0] seq2 [7];

  initial begin
    // Test 1: reset, then a single start pulse.
    add(1'b0, 1'b1, 1'b0, E_IDLE, 1);
    add(1'b0, 1'b1, 1'b0, E_IDLE, 1);
    add(1'b0, 1'b0, 1'b0, E_IDLE, 1);
    add_op(16'h0000, 1);
    // Test 2: start held high; next op begins the cycle after IDLE.
    add_op(16'hFFFF, 2);
    add_op(16'h0000, 2);
    // Test 3: reset during the third IT_B (cycle 8), then a full op.
    add(1'b1, 1'b0, 1'b0, E_IAA, 3);
    for (int k = 1; k <= 7; k++) add(1'b0, 1'b0, 1'b0, exp_of(k + 1), 3);
    add(1'b0, 1'b1, 1'b0, E_IDLE, 3);
    add(1'b0, 1'b0, 1'b0, E_IDLE, 3);
    add(1'b0, 1'b0, 1'b0, E_IDLE, 3);
    add_op(16'h0000, 3);
    // Test 4: stray starts in cycles 3, 8 and 14 are ignored.
    add_op(16'h4108, 4);
    add(1'b0, 1'b0, 1'b0, E_IDLE, 4);
    add(1'b0, 1'b0, 1'b0, E_IDLE, 4);
`ifdef FPDIV_CTRL_ABORT_EN
    // Test 6: abort in cycle 7, then abort+start together in IDLE.
    add(1'b1, 1'b0, 1'b0, E_IAA, 6);
    for (int k = 1; k <= 6; k++) add(1'b0, 1'b0, 1'b0, exp_of(k + 1), 6);
    add(1'b0, 1'b0, 1'b1, E_IDLE, 6);
    add(1'b1, 1'b0, 1'b1, E_IAA, 6);
    for (int k = 1; k <= 14; k++) add(1'b0, 1'b0, 1'b0, exp_of(k + 1), 6);
    add(1'b0, 1'b0, 1'b1, E_IDLE, 6);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].start;
      reset = vq[i].reset;
`ifdef FPDIV_CTRL_ABORT_EN
      abort = vq[i].abort;
`endif
      @(posedge clk);
      #1;
      check($sformatf("t%0d_vec", vq[i].tag), i, obs, vq[i].exp);
    end

    // Test 5: ITERS=2 instance.
    seq2[0] = E_IAA; seq2[1] = E_IAB; seq2[2] = E_ITA; seq2[3] = E_ITB;
    seq2[4] = E_REM; seq2[5] = E_DONE; seq2[6] = E_IDLE;
    @(negedge clk); reset2 = 1'b1; start2 = 1'b0;
    @(posedge clk); #1;
    check("t5_reset", 0, obs2, E_IDLE);
    @(negedge clk); reset2 = 1'b0; start2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      check("t5_seq", c + 1, obs2, seq2[c]);
      @(negedge clk); start2 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
